fifo_queue: RTL and testbench
=============================

FIFO_QUEUE -- requirements
Module: fifo_queue

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 16, giving the payload width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 4, giving the entry count; only power-of-two values from 2 to 16 SHALL be legal.
REQ-003 The block SHALL have port CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port FIFOQUEUE_RST_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port FIFOQUEUE_Flush, input, 1 bit: synchronous clear of contents.
REQ-006 The block SHALL have port FIFOQUEUE_InValid, input, 1 bit: the producer offers a word.
REQ-007 The block SHALL have port FIFOQUEUE_InData, input, DATA_WIDTH bits: the producer word.
REQ-008 The block SHALL have port FIFOQUEUE_InReady, output, 1 bit: the queue can accept a word.
REQ-009 The block SHALL have port FIFOQUEUE_OutValid, output, 1 bit: the head word is available.
REQ-010 The block SHALL have port FIFOQUEUE_OutData, output, DATA_WIDTH bits: the head word.
REQ-011 The block SHALL have port FIFOQUEUE_OutReady, input, 1 bit: the consumer takes the head word.
REQ-012 The block SHALL have port FIFOQUEUE_Count, output, log2(DEPTH)+1 bits: occupancy from 0 to DEPTH.
REQ-013 The block SHALL have port FIFOQUEUE_Overflow, output, 1 bit: sticky flag, push attempted while full.
REQ-014 The block SHALL have port FIFOQUEUE_Underflow, output, 1 bit: sticky flag, pop attempted while empty.

Function
REQ-015 A push SHALL occur when InValid and InReady are both 1 at a rising edge; a pop SHALL occur when OutValid and OutReady are both 1 at a rising edge.
REQ-016 InReady SHALL equal (Count != DEPTH) and OutValid SHALL equal (Count != 0), both decoded only from registered state.
REQ-017 The queue SHALL be first-word-fall-through: OutData SHALL equal the storage entry at the read pointer, with no added register stage.
REQ-018 A word pushed at edge N SHALL appear on OutData with OutValid=1 after edge N if the queue was empty before edge N.
REQ-019 The write and read pointers SHALL be log2(DEPTH) bits wide and SHALL wrap from DEPTH-1 to 0.
REQ-020 On a push without a pop, Count SHALL increment by 1; on a pop without a push, it SHALL decrement by 1; on a simultaneous push and pop, or neither, it SHALL be unchanged.
REQ-021 When full, a simultaneous pop and InValid=1 SHALL pop only, because InReady=0; Count SHALL become DEPTH-1.
REQ-022 When empty, a simultaneous push and OutReady=1 SHALL push only; Count SHALL become 1.
REQ-023 Overflow SHALL set when InValid=1 and Count=DEPTH at an edge; Underflow SHALL set when OutReady=1 and Count=0 at an edge; neither SHALL alter pointers, Count or storage.
REQ-024 Both error flags SHALL stay set until reset or Flush.
REQ-025 Flush SHALL take priority over push and pop at the same edge, and SHALL clear the pointers, Count, Overflow and Underflow; storage contents need not be cleared.
REQ-026 Storage SHALL be written only on a push.

Reset
REQ-027 While FIFOQUEUE_RST_n=0, the pointers, Count, Overflow and Underflow SHALL be 0, OutValid SHALL be 0, and InReady SHALL be 1, regardless of CLK.
REQ-028 Storage entries SHALL NOT be reset; OutData is don't-care while OutValid=0.
REQ-029 Reset asserted mid-operation SHALL discard all queued words, and operation SHALL resume on the first edge after deassertion.

Structure
REQ-030 A shared package SHALL hold the DATA_WIDTH and DEPTH defaults and a pointer-width function clog2(DEPTH).
REQ-031 The occupancy tracking SHALL be a sub-module, fifo_occupancy, taking push, pop and flush and returning Count, Full and Empty.
REQ-032 Storage, pointers and the error flags SHALL live in fifo_queue.

Verification
REQ-033 After reset, push 0x1111, 0x2222, 0x3333 and 0x4444 with OutReady=0: Count SHALL be 4, InReady 0, and OutData 0x1111.
REQ-034 From full, hold InValid=1 with 0x5555 for 1 cycle with OutReady=0: Overflow SHALL be 1, Count SHALL stay 4, and OutData SHALL stay 0x1111.
REQ-035 From full, set OutReady=1 and InValid=1 with 0x5555: the first cycle SHALL pop only (Count 3); then streaming SHALL hold Count at 3, with output order 0x2222, 0x3333, 0x4444, 0x5555.
REQ-036 From empty, set OutReady=1 for 1 cycle: Underflow SHALL be 1 and Count SHALL be 0; then push 0xAAAA: OutValid SHALL be 1 and OutData 0xAAAA one edge later.
REQ-037 With Count=2, assert Flush together with a push: the following cycle SHALL show Count 0, OutValid 0, and both flags 0.
REQ-038 Push 6 and pop 6 interleaved across the wrap: the data order SHALL be preserved, and asserting RST_n=0 mid-stream SHALL immediately give Count 0 and OutValid 0.

Source files
------------

// File: rtl/fifo_queue_pkg.sv
// Shared defaults and helpers for the first-word-fall-through queue.
package fifo_queue_pkg;

  localparam int DEFAULT_DATA_WIDTH = 16;
  localparam int DEFAULT_DEPTH      = 4;

  // Smallest n with 2**n >= value; used for pointer widths.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/fifo_occupancy.sv
// Occupancy counter for the queue: tracks Count and derives Full/Empty.
module fifo_occupancy
  import fifo_queue_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int PTR_W = clog2(DEPTH)
) (
  input  logic           CLK,
  input  logic           rstN,
  input  logic           pushEn,
  input  logic           popEn,
  input  logic           flushEn,
  output logic [PTR_W:0] count,
  output logic           full,
  output logic           empty
);

  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

  always_ff @(posedge CLK or negedge rstN) begin
    if (!rstN) begin
      count <= '0;
    end else if (flushEn) begin
      count <= '0;
    end else if (pushEn && !popEn) begin
      count <= count + 1'b1;
    end else if (popEn && !pushEn) begin
      count <= count - 1'b1;
    end
  end

  assign full  = (count == FULL_COUNT);
  assign empty = (count == '0);

endmodule

// File: rtl/fifo_queue.sv
// First-word-fall-through queue with sticky overflow/underflow flags and flush.
module fifo_queue
  import fifo_queue_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int DEPTH      = DEFAULT_DEPTH
) (
  input  logic                    CLK,
  input  logic                    FIFOQUEUE_RST_n,
  input  logic                    FIFOQUEUE_Flush,
  input  logic                    FIFOQUEUE_InValid,
  input  logic [DATA_WIDTH-1:0]   FIFOQUEUE_InData,
  output logic                    FIFOQUEUE_InReady,
  output logic                    FIFOQUEUE_OutValid,
  output logic [DATA_WIDTH-1:0]   FIFOQUEUE_OutData,
  input  logic                    FIFOQUEUE_OutReady,
  output logic [clog2(DEPTH):0]   FIFOQUEUE_Count,
  output logic                    FIFOQUEUE_Overflow,
  output logic                    FIFOQUEUE_Underflow
);

  localparam int PTR_W = clog2(DEPTH);

  if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0) begin : gIllegalDepth
    $error("fifo_queue: DEPTH must be a power of two from 2 to 16");
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wrPtr;
  logic [PTR_W-1:0]      rdPtr;
  logic                  full;
  logic                  empty;
  logic                  pushFire;
  logic                  popFire;
  logic                  overflowQ;
  logic                  underflowQ;

  // Handshake: a word moves on a rising edge only when valid and ready are both
  // high on that side; ready/valid come from registered occupancy, never from
  // the partner's valid/ready, so there is no combinational path across the queue.
  assign pushFire = FIFOQUEUE_InValid && !full;
  assign popFire  = FIFOQUEUE_OutReady && !empty;

  fifo_occupancy #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) uOccupancy (
    .CLK     (CLK),
    .rstN    (FIFOQUEUE_RST_n),
    .pushEn  (pushFire),
    .popEn   (popFire),
    .flushEn (FIFOQUEUE_Flush),
    .count   (FIFOQUEUE_Count),
    .full    (full),
    .empty   (empty)
  );

  // Storage is deliberately unreset; a flush suppresses the write at its edge.
  always_ff @(posedge CLK) begin
    if (pushFire && !FIFOQUEUE_Flush) begin
      mem[wrPtr] <= FIFOQUEUE_InData;
    end
  end

  always_ff @(posedge CLK or negedge FIFOQUEUE_RST_n) begin
    if (!FIFOQUEUE_RST_n) begin
      wrPtr      <= '0;
      rdPtr      <= '0;
      overflowQ  <= 1'b0;
      underflowQ <= 1'b0;
    end else if (FIFOQUEUE_Flush) begin
      wrPtr      <= '0;
      rdPtr      <= '0;
      overflowQ  <= 1'b0;
      underflowQ <= 1'b0;
    end else begin
      if (pushFire) begin
        wrPtr <= wrPtr + 1'b1;
      end
      if (popFire) begin
        rdPtr <= rdPtr + 1'b1;
      end
      if (FIFOQUEUE_InValid && full) begin
        overflowQ <= 1'b1;
      end
      if (FIFOQUEUE_OutReady && empty) begin
        underflowQ <= 1'b1;
      end
    end
  end

  assign FIFOQUEUE_InReady   = !full;
  assign FIFOQUEUE_OutValid  = !empty;
  assign FIFOQUEUE_OutData   = mem[rdPtr];
  assign FIFOQUEUE_Overflow  = overflowQ;
  assign FIFOQUEUE_Underflow = underflowQ;

endmodule

// File: tb/tb_fifo_queue.sv
// Directed bench for fifo_queue: queue-based reference model plus literal checks.
module tb_fifo_queue;

  localparam int DW    = 16;
  localparam int DEPTH = 4;

  logic          CLK;
  logic          rstN;
  logic          flush;
  logic          inValid;
  logic [DW-1:0] inData;
  logic          inReady;
  logic          outValid;
  logic [DW-1:0] outData;
  logic          outReady;
  logic [2:0]    count;
  logic          overflow;
  logic          underflow;

  int vectors;
  int miscompares;

  // Reference model state
  logic [DW-1:0] exp_q[$];
  logic          expOverflow;
  logic          expUnderflow;
  logic          checkEn;

  fifo_queue #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH)
  ) dut (
    .CLK                 (CLK),
    .FIFOQUEUE_RST_n     (rstN),
    .FIFOQUEUE_Flush     (flush),
    .FIFOQUEUE_InValid   (inValid),
    .FIFOQUEUE_InData    (inData),
    .FIFOQUEUE_InReady   (inReady),
    .FIFOQUEUE_OutValid  (outValid),
    .FIFOQUEUE_OutData   (outData),
    .FIFOQUEUE_OutReady  (outReady),
    .FIFOQUEUE_Count     (count),
    .FIFOQUEUE_Overflow  (overflow),
    .FIFOQUEUE_Underflow (underflow)
  );

  // Clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a plain queue with the queue rules applied at each edge
  always @(posedge CLK or negedge rstN) begin
    if (!rstN) begin
      exp_q.delete();
      expOverflow  = 1'b0;
      expUnderflow = 1'b0;
    end else if (flush) begin
      exp_q.delete();
      expOverflow  = 1'b0;
      expUnderflow = 1'b0;
    end else begin
      automatic bit wasFull  = (exp_q.size() == DEPTH);
      automatic bit wasEmpty = (exp_q.size() == 0);
      if (inValid && wasFull)   expOverflow  = 1'b1;
      if (outReady && wasEmpty) expUnderflow = 1'b1;
      if (outReady && !wasEmpty) void'(exp_q.pop_front());
      if (inValid && !wasFull)   exp_q.push_back(inData);
    end
  end

  // Compare process
  always @(negedge CLK) begin
    if (checkEn) begin
      check("count", 32'(count), 32'(exp_q.size()));
      check("in_ready", 32'(inReady), 32'(exp_q.size() != DEPTH));
      check("out_valid", 32'(outValid), 32'(exp_q.size() != 0));
      check("overflow", 32'(overflow), 32'(expOverflow));
      check("underflow", 32'(underflow), 32'(expUnderflow));
      if (exp_q.size() != 0) check("out_data", 32'(outData), 32'(exp_q[0]));
    end
  end

  // Driver: apply inputs for one edge, return 1 time unit after it
  task automatic step(input logic v, input logic [DW-1:0] d, input logic r, input logic f);
    inValid  = v;
    inData   = d;
    outReady = r;
    flush    = f;
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    step(1'b0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    checkEn     = 1'b0;
    expOverflow = 1'b0;
    expUnderflow = 1'b0;
    rstN     = 1'b0;
    flush    = 1'b0;
    inValid  = 1'b0;
    inData   = '0;
    outReady = 1'b0;

    // Reset state, held across a clock edge
    @(posedge CLK);
    #2;
    check("rst_count", 32'(count), 0);
    check("rst_in_ready", 32'(inReady), 1);
    check("rst_out_valid", 32'(outValid), 0);
    check("rst_overflow", 32'(overflow), 0);
    check("rst_underflow", 32'(underflow), 0);
    checkEn = 1'b1;
    @(negedge CLK);
    rstN = 1'b1;

    // Fill to full without popping
    step(1'b1, 16'h1111, 1'b0, 1'b0);
    check("first_word_fallthrough", 32'(outData), 32'h1111);
    step(1'b1, 16'h2222, 1'b0, 1'b0);
    step(1'b1, 16'h3333, 1'b0, 1'b0);
    step(1'b1, 16'h4444, 1'b0, 1'b0);
    check("full_count", 32'(count), 4);
    check("full_in_ready", 32'(inReady), 0);
    check("full_head", 32'(outData), 32'h1111);

    // Push while full
    step(1'b1, 16'h5555, 1'b0, 1'b0);
    check("ovf_flag", 32'(overflow), 1);
    check("ovf_count", 32'(count), 4);
    check("ovf_head", 32'(outData), 32'h1111);

    // Pop-only from full, then streaming at constant occupancy
    step(1'b1, 16'h5555, 1'b1, 1'b0);
    check("full_pop_count", 32'(count), 3);
    check("full_pop_head", 32'(outData), 32'h2222);
    step(1'b1, 16'h5555, 1'b1, 1'b0);
    check("stream1_count", 32'(count), 3);
    check("stream1_head", 32'(outData), 32'h3333);
    step(1'b1, 16'h6666, 1'b1, 1'b0);
    check("stream2_head", 32'(outData), 32'h4444);
    step(1'b1, 16'h7777, 1'b1, 1'b0);
    check("stream3_count", 32'(count), 3);
    check("stream3_head", 32'(outData), 32'h5555);

    // Drain
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    check("drained_count", 32'(count), 0);
    check("ovf_sticky", 32'(overflow), 1);

    // Pop while empty, then push into empty
    step(1'b0, '0, 1'b1, 1'b0);
    check("udf_flag", 32'(underflow), 1);
    check("udf_count", 32'(count), 0);
    step(1'b1, 16'hAAAA, 1'b0, 1'b0);
    check("push_empty_valid", 32'(outValid), 1);
    check("push_empty_data", 32'(outData), 32'hAAAA);

    // Flush beats a same-edge push
    step(1'b1, 16'hBBBB, 1'b0, 1'b0);
    check("pre_flush_count", 32'(count), 2);
    step(1'b1, 16'hCCCC, 1'b0, 1'b1);
    check("flush_count", 32'(count), 0);
    check("flush_valid", 32'(outValid), 0);
    check("flush_ovf", 32'(overflow), 0);
    check("flush_udf", 32'(underflow), 0);

    // Six pushes and six pops interleaved across the pointer wrap
    idle();
    step(1'b1, 16'h0A01, 1'b0, 1'b0);
    step(1'b1, 16'h0A02, 1'b0, 1'b0);
    step(1'b1, 16'h0A03, 1'b1, 1'b0);
    check("wrap_head1", 32'(outData), 32'h0A02);
    step(1'b1, 16'h0A04, 1'b1, 1'b0);
    step(1'b1, 16'h0A05, 1'b1, 1'b0);
    step(1'b1, 16'h0A06, 1'b1, 1'b0);
    check("wrap_head2", 32'(outData), 32'h0A05);
    step(1'b0, '0, 1'b1, 1'b0);
    check("wrap_head3", 32'(outData), 32'h0A06);
    step(1'b0, '0, 1'b1, 1'b0);
    check("wrap_empty", 32'(count), 0);

    // Asynchronous reset mid-stream
    step(1'b1, 16'h0B01, 1'b0, 1'b0);
    step(1'b1, 16'h0B02, 1'b1, 1'b0);
    step(1'b1, 16'h0B03, 1'b0, 1'b0);
    #1;
    rstN = 1'b0;
    #1;
    check("async_rst_count", 32'(count), 0);
    check("async_rst_valid", 32'(outValid), 0);
    check("async_rst_ready", 32'(inReady), 1);
    step(1'b1, 16'h0C01, 1'b0, 1'b0);
    check("rst_held_count", 32'(count), 0);
    @(negedge CLK);
    rstN = 1'b1;
    step(1'b1, 16'h0D01, 1'b0, 1'b0);
    check("resume_count", 32'(count), 1);
    check("resume_data", 32'(outData), 32'h0D01);
    step(1'b0, '0, 1'b1, 1'b0);
    idle();
    idle();

    @(negedge CLK);
    checkEn = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
